// File: rtl/f_pkg.sv
// Shared definitions for the fetch stage: default address map, fetch-entry
// layout and the instruction used to replace faulting fetches.
package f_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_PC_LO    = 32'h0000_3000;
    localparam logic [31:0] DEF_PC_HI    = 32'h0000_6FFC;

    // Instruction substituted for a fetch from an illegal address.
    localparam logic [31:0] NOP = 32'h0000_0000;

    // One queued fetch: where it came from, what was read, and whether the
    // address was illegal. The ring stores this flattened as {pc, instr, adel}.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_entry_t;

endpackage

// File: rtl/f_ifq_ring.sv
// DEPTH-entry circular buffer holding flattened fetch entries.
// enq_i/deq_i arrive already qualified by the caller; clear_i empties the
// ring and overrides both. Entry storage is not reset: a slot is only ever
// read after it has been written.
module f_ifq_ring #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 65
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear_i,
    input  logic                       enq_i,
    input  logic                       deq_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    output logic [DATA_W-1:0]          head_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_i) tail_d = tail_q + PW'(1);
            if (deq_i) head_d = head_q + PW'(1);
            count_d = count_q + CW'(enq_i) - CW'(deq_i);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry write at the tail; when full with a dequeue this reuses the head slot being retired.
    always_ff @(posedge clk) begin
        if (enq_i && !clear_i) mem_q[tail_q] <= wr_data_i;
    end

    assign head_data_o = mem_q[head_q];
    assign count_o     = count_q;
    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/f_ifq.sv
// Fetch stage: PC register feeding a combinational instruction memory, and a
// DEPTH-entry queue towards decode. One word is fetched per cycle while the
// queue has room (or is being drained); a redirect flushes and re-steers.
//
// Handshake: out_valid_o means the head entry is meaningful; the head is
// consumed on a rising edge where deq_i && out_valid_o. deq_i while empty is
// ignored. All out_* signals come straight from registered queue state.
//
// Optional macro F_ADEL_CHECK_EN: flag fetches outside [PC_LO, PC_HI] or
// misaligned, storing a NOP with adel=1. Without it adel is always 0.
module f_ifq
    import f_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] PC_LO    = WIDTH'(DEF_PC_LO),
    parameter logic [WIDTH-1:0] PC_HI    = WIDTH'(DEF_PC_HI)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect_i,
    input  logic [WIDTH-1:0]       redirect_pc_i,
    output logic [WIDTH-1:0]       im_addr_o,
    input  logic [31:0]            im_rdata_i,
    input  logic                   deq_i,
    output logic                   out_valid_o,
    output logic [WIDTH-1:0]       out_pc_o,
    output logic [31:0]            out_instr_o,
    output logic                   out_adel_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int ENTRY_W = WIDTH + 32 + 1;

    logic [WIDTH-1:0]   pc_q, pc_d;
    logic               full, empty;
    logic               do_deq, do_enq;
    logic               adel;
    logic [31:0]        wr_instr;
    logic [ENTRY_W-1:0] head_data;

`ifdef F_ADEL_CHECK_EN
    // Illegal fetch: misaligned or outside the legal window; the word is replaced by a NOP.
    always_comb begin
        adel     = (pc_q[1:0] != 2'b00) || (pc_q < PC_LO) || (pc_q > PC_HI);
        wr_instr = adel ? NOP : im_rdata_i;
    end
`else
    // No address checking: every fetch is stored as read.
    always_comb begin
        adel     = 1'b0;
        wr_instr = im_rdata_i;
    end
`endif

    assign do_deq = deq_i && !empty;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign do_enq = !redirect_i && (!full || do_deq);

    // Next PC: redirect wins, otherwise advance only when the current word was taken.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i)  pc_d = redirect_pc_i;
        else if (do_enq) pc_d = pc_q + WIDTH'(4);
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    f_ifq_ring #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_ring (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (redirect_i),
        .enq_i       (do_enq),
        .deq_i       (do_deq && !redirect_i),
        .wr_data_i   ({pc_q, wr_instr, adel}),
        .head_data_o (head_data),
        .count_o     (count_o),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign im_addr_o   = pc_q;
    assign out_valid_o = !empty;
    assign out_pc_o    = head_data[ENTRY_W-1 -: WIDTH];
    assign out_instr_o = head_data[32:1];
    assign out_adel_o  = head_data[0];

endmodule

// File: tb/tb_f_ifq.sv
// Bench for f_ifq: a fixed vector table walking through fill, pass-through,
// redirect, reset and address-error cases, followed by a random phase. A
// queue-based reference of the fetch queue checks every cycle.
module tb_f_ifq;

    localparam int DEPTH = 4;

`ifdef F_ADEL_CHECK_EN
    localparam bit ADEL_ON = 1'b1;
`else
    localparam bit ADEL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        deq = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_adel;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    f_ifq #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .im_addr_o     (im_addr),
        .im_rdata_i    (im_rdata),
        .deq_i         (deq),
        .out_valid_o   (out_valid),
        .out_pc_o      (out_pc),
        .out_instr_o   (out_instr),
        .out_adel_o    (out_adel),
        .count_o       (count)
    );

    // Address-derived instruction memory contents.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    assign im_rdata = imem(im_addr);

    function automatic logic model_adel(input logic [31:0] a);
        return ADEL_ON && ((a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC));
    endfunction

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] m_pc;
    logic [64:0] exp_q[$];   // {pc, instr, adel}

    task automatic model_step(input logic r, input logic rd, input logic [31:0] rpc, input logic d);
        logic dq, en, ad;
        if (r) begin
            m_pc = 32'h0000_3000;
            exp_q.delete();
        end else if (rd) begin
            m_pc = rpc;
            exp_q.delete();
        end else begin
            dq = d && (exp_q.size() != 0);
            en = (exp_q.size() < DEPTH) || dq;
            if (dq) void'(exp_q.pop_front());
            if (en) begin
                ad = model_adel(m_pc);
                exp_q.push_back({m_pc, (ad ? 32'h0 : imem(m_pc)), ad});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic sb_check();
        logic [64:0] h;
        chk("sb_count", 32'(count), 32'(exp_q.size()));
        chk("sb_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("sb_im_addr", im_addr, m_pc);
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            chk("sb_out_pc", out_pc, h[64:33]);
            chk("sb_out_instr", out_instr, h[32:1]);
            chk("sb_out_adel", 32'(out_adel), 32'(h[0]));
        end
    endtask

    // ---------------- driver ----------------
    // Drive inputs for one rising edge, advance the model, then sample on the falling edge.
    task automatic cycle(input logic r, input logic rd, input logic [31:0] rpc, input logic d);
        reset       = r;
        redirect    = rd;
        redirect_pc = rpc;
        deq         = d;
        model_step(r, rd, rpc, d);
        @(posedge clk);
        @(negedge clk);
        sb_check();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        rd;
        logic [31:0] rpc;
        logic        dq;
        int          cnt;
        logic        vld;
        logic [31:0] ima;
        logic        chk_pc;
        logic [31:0] hpc;
        logic        chk_adel;
        logic        adel;
        logic        chk_instr;
        logic [31:0] instr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rst, input logic rd, input logic [31:0] rpc,
                                input logic dq, input int cnt, input logic vld,
                                input logic [31:0] ima, input logic chk_pc, input logic [31:0] hpc);
        vec_t v;
        v.rst = rst; v.rd = rd; v.rpc = rpc; v.dq = dq;
        v.cnt = cnt; v.vld = vld; v.ima = ima; v.chk_pc = chk_pc; v.hpc = hpc;
        v.chk_adel = 1'b0; v.adel = 1'b0; v.chk_instr = 1'b0; v.instr = 32'h0;
        return v;
    endfunction

    initial begin
        vec_t v;
        logic r, rd, d;
        logic [31:0] rpc;

        // reset held
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 32'h3000, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 32'h3000, 0, 0));
        // fill with deq=0
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 32'h3004, 1, 32'h3000));
        vt.push_back(mk(0, 0, 0, 0, 2, 1, 32'h3008, 1, 32'h3000));
        vt.push_back(mk(0, 0, 0, 0, 3, 1, 32'h300C, 1, 32'h3000));
        vt.push_back(mk(0, 0, 0, 0, 4, 1, 32'h3010, 1, 32'h3000));
        vt.push_back(mk(0, 0, 0, 0, 4, 1, 32'h3010, 1, 32'h3000));
        // full with deq held: pass-through
        for (int i = 1; i <= 8; i++)
            vt.push_back(mk(0, 0, 0, 1, 4, 1, 32'h3010 + 32'(4 * i), 1, 32'h3000 + 32'(4 * i)));
        // get to count=3, then redirect with a simultaneous deq
        vt.push_back(mk(0, 1, 32'h3100, 0, 0, 0, 32'h3100, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 32'h3104, 1, 32'h3100));
        vt.push_back(mk(0, 0, 0, 0, 2, 1, 32'h3108, 1, 32'h3100));
        vt.push_back(mk(0, 0, 0, 0, 3, 1, 32'h310C, 1, 32'h3100));
        vt.push_back(mk(0, 1, 32'h3400, 1, 0, 0, 32'h3400, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 32'h3404, 1, 32'h3400));
        vt.push_back(mk(0, 0, 0, 0, 2, 1, 32'h3408, 1, 32'h3400));
        // reset mid-stream with count=2
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 32'h3000, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 32'h3004, 1, 32'h3000));
        // deq on empty queue is ignored; then steady one-per-cycle drain
        vt.push_back(mk(0, 1, 32'h3200, 1, 0, 0, 32'h3200, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 1, 1, 32'h3204, 1, 32'h3200));
        vt.push_back(mk(0, 0, 0, 1, 1, 1, 32'h3208, 1, 32'h3204));
        vt.push_back(mk(0, 0, 0, 1, 1, 1, 32'h320C, 1, 32'h3208));
        // address error cases
        vt.push_back(mk(0, 1, 32'h3002, 0, 0, 0, 32'h3002, 0, 0));
        v = mk(0, 0, 0, 0, 1, 1, 32'h3006, 1, 32'h3002);
        v.chk_adel = 1; v.adel = ADEL_ON;
        v.chk_instr = 1; v.instr = ADEL_ON ? 32'h0 : imem(32'h3002);
        vt.push_back(v);
        vt.push_back(mk(0, 1, 32'h7000, 0, 0, 0, 32'h7000, 0, 0));
        v = mk(0, 0, 0, 0, 1, 1, 32'h7004, 1, 32'h7000);
        v.chk_adel = 1; v.adel = ADEL_ON;
        vt.push_back(v);
        vt.push_back(mk(0, 1, 32'h6FFC, 0, 0, 0, 32'h6FFC, 0, 0));
        v = mk(0, 0, 0, 0, 1, 1, 32'h7000, 1, 32'h6FFC);
        v.chk_adel = 1; v.adel = 1'b0;
        v.chk_instr = 1; v.instr = imem(32'h6FFC);
        vt.push_back(v);
        // drain past the top of the legal window
        v = mk(0, 0, 0, 1, 1, 1, 32'h7004, 1, 32'h7000);
        v.chk_adel = 1; v.adel = ADEL_ON;
        vt.push_back(v);

        // apply table
        @(negedge clk);
        foreach (vt[i]) begin
            cycle(vt[i].rst, vt[i].rd, vt[i].rpc, vt[i].dq);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].cnt));
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vt[i].vld));
            chk($sformatf("v%0d_im_addr", i), im_addr, vt[i].ima);
            if (vt[i].chk_pc)    chk($sformatf("v%0d_out_pc", i), out_pc, vt[i].hpc);
            if (vt[i].chk_adel)  chk($sformatf("v%0d_out_adel", i), 32'(out_adel), 32'(vt[i].adel));
            if (vt[i].chk_instr) chk($sformatf("v%0d_out_instr", i), out_instr, vt[i].instr);
        end

        // random traffic, checked by the scoreboard every cycle
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 63) == 0);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = 32'($urandom_range(32'h2FF0, 32'h7010));
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            d   = ($urandom_range(0, 2) != 0);
            cycle(r, rd, rpc, d);
        end

        // wrap of the PC at the top of the address space
        cycle(0, 1, 32'hFFFF_FFF8, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        chk("pc_wrap", im_addr, 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/f_ifq.md
# f_ifq

Parametrised fetch stage replacing the bare PC register: a PC generator plus a DEPTH-entry instruction queue between the combinational instruction memory and decode. It fetches one word per cycle while the queue has room, hands entries to decode under a valid/dequeue handshake, and flushes and re-steers on branch/jump redirects. It sits in F, and its outputs feed the F/D boundary.

## Interface
- `WIDTH`, 32: PC and address width.
- `RESET_PC`, 32'h0000_3000: PC loaded on reset.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `PC_LO`, 32'h0000_3000: lowest legal fetch address (used only with `F_ADEL_CHECK_EN`).
- `PC_HI`, 32'h0000_6FFC: highest legal fetch address (used only with `F_ADEL_CHECK_EN`).
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `redirect` in 1: flush the queue and load `redirect_pc`.
- `redirect_pc` in WIDTH: new fetch PC.
- `im_addr` out WIDTH: equals the internal `pc`; drives the instruction memory.
- `im_rdata` in 32: combinational instruction-memory read data for `im_addr`.
- `deq` in 1: decode consumes the head entry. Ignored when `out_valid`=0.
- `out_valid` out 1: the queue is non-empty.
- `out_pc` out WIDTH: PC of the head entry.
- `out_instr` out 32: instruction of the head entry.
- `out_adel` out 1: the head entry has a fetch address error.
- `count` out $clog2(DEPTH)+1: number of occupied entries.

## Operation
- State: `pc`, head pointer, tail pointer, `count`, and DEPTH entries of {pc, instr, adel}.
- Definitions:
  - `full` = (count==DEPTH)
  - `do_deq` = deq && out_valid
  - `do_enq` = !redirect && (!full || do_deq)
- Precedence each edge: reset > redirect > normal operation.
- Reset:
  - `pc`←RESET_PC; pointers and count←0.
  - Entry contents are don't-care.
  - Outputs after reset: `out_valid`=0, `count`=0, `im_addr`=RESET_PC. `out_pc`, `out_instr` and `out_adel` are don't-care while `out_valid`=0.
- Redirect:
  - Pointers and count←0; `pc`←redirect_pc.
  - `deq` in the same cycle is discarded, and no enqueue occurs.
- Normal operation:
  - On `do_enq`: write {pc, im_rdata, adel(pc)} at the tail, advance the tail, `pc`←pc+4.
  - Otherwise `pc` holds.
  - On `do_deq`: advance the head.
  - `count`←count + do_enq − do_deq.
- Full and dequeue in the same cycle: enqueue is allowed (pass-through), so `count` stays at DEPTH.
- Empty queue with `deq`=1: no effect.
- Pointers wrap modulo DEPTH. `pc` wraps modulo 2^WIDTH without error.
- Outputs are driven from the registered head entry. There is no combinational path from `im_rdata` or `deq` to any `out_*` signal.

## Timing
- Fetch-to-visible latency is 1 cycle: a word fetched at edge N is presented at the head after edge N if the queue was empty.
- First edge after reset is released: entry {RESET_PC, im_rdata} is enqueued; `out_valid`=1 from the following cycle.
- Redirect at edge N:
  - `out_valid`=0 in cycle N+1, with `im_addr`=redirect_pc.
  - The first redirected entry is visible in cycle N+2.
- With continuous `deq`=1, sustained throughput is 1 entry per cycle.
- With `deq`=0, the queue fills in DEPTH cycles. `pc` then stops at the address of the first un-enqueued word.

## Configuration
- `F_ADEL_CHECK_EN` defined:
  - adel(pc) = (pc[1:0]!=0) || pc<PC_LO || pc>PC_HI.
  - For an adel entry, the stored instr is forced to 32'h0000_0000 (nop) and the stored adel=1.
- `F_ADEL_CHECK_EN` undefined:
  - adel logic is absent; `out_adel` is tied to 0.
  - `im_rdata` is stored unchanged.
  - `PC_LO` and `PC_HI` are unused.

## Structure
- Shared package `f_pkg` holds:
  - default RESET_PC, PC_LO and PC_HI constants;
  - the fetch-entry struct type {pc, instr, adel};
  - the NOP constant.
- One sub-module, `f_ifq_ring`: DEPTH-entry ring storage with head/tail/count, an enq/deq/clear interface and full/empty outputs.
- `f_ifq` itself owns the PC register, the enqueue/redirect control and the adel check.

## Test plan
- Reset held, then released with `deq`=0 and `im_rdata`=addr-derived:
  - 4 edges later, `count`=4 and `im_addr`=0x3010.
  - `out_pc`=0x3000; `pc` then holds.
- Full queue with `deq`=1 held for 8 cycles: `count` stays at 4 and `out_pc` increments by 4 each cycle.
- Redirect to 0x3400 with `count`=3 and `deq`=1 in the same cycle:
  - next cycle `count`=0, `out_valid`=0, `im_addr`=0x3400;
  - the following cycle `out_pc`=0x3400.
- Reset asserted mid-stream with `count`=2: next cycle `count`=0 and `im_addr`=0x3000.
- With `F_ADEL_CHECK_EN` defined:
  - redirect to 0x3002 gives head `out_adel`=1 and `out_instr`=0;
  - redirect to 0x7000 also gives `out_adel`=1;
  - redirect to 0x6FFC gives `out_adel`=0.
- With `F_ADEL_CHECK_EN` undefined, the same redirect to 0x3002 gives `out_adel`=0 and `out_instr`=im_rdata.
